io_controller: RTL

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/io_controller.sv
// io_controller: user I/O sequencer for the processor core.
//   Debounces the insert pushbutton, captures SW on an accepted press when an
//   instruction requests input, and runs a 32-cycle shift-add-3 binary-to-BCD
//   conversion to drive eight 7-segment digits when an instruction requests
//   output. stall freezes the PC while either request is outstanding.
// Ports:
//   CLK, reset        processor clock, asynchronous active-low reset
//   insert, SW        raw pushbutton level (high = pressed), 18-bit switch value
//   input_flag        current instruction requests user input
//   output_flag       current instruction requests display of out_data
//   out_data          value to display
//   halt              processor halted: ignore new requests, never stall
//   stall             PC freeze
//   user_input        captured {14'b0, SW}
//   busy              display conversion in progress
//   HEX0..HEX7        active-low segments {g,f,e,d,c,b,a}, HEX0 least significant
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        insert,
  input  logic [17:0] SW,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic [31:0] out_data,
  input  logic        halt,
  output logic        stall,
  output logic [31:0] user_input,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, CONVERT} state_t;
  state_t state_q, state_d;
  logic lvl_q;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [31:0] sh_q, sh_d, ui_q, ui_d;
  logic [39:0] bcd_q, bcd_d, adj;
  logic [5:0] bit_q, bit_d;
  logic [6:0] hex_q [8];
  logic [6:0] hex_d [8];
  logic [6:0] enc [8];
  logic stable, done, stall_c, lead;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction

  // lvl_q/dcnt_q: last sampled insert level and how many consecutive samples it has held
  assign stable = dcnt_q == DMAX;
  assign done = bit_q == 6'd32;
  assign dcnt_d = (insert != lvl_q) ? CW'(1) : stable ? dcnt_q : dcnt_q + CW'(1);
  assign busy = (state_q == CONVERT) && !done;
  assign stall = stall_c && !halt && reset;
  assign user_input = ui_q;
  assign {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} =
    {hex_q[7], hex_q[6], hex_q[5], hex_q[4], hex_q[3], hex_q[2], hex_q[1], hex_q[0]};

  always_comb begin
    for (int i = 0; i < 10; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  // Nine or more decimal digits means the value is >= 100000000 and overflows the display
  always_comb begin
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      lead = lead && (bcd_q[4*i +: 4] == 4'd0);
      enc[i] = (|bcd_q[39:32]) ? DASH : lead ? BLANK : seg(bcd_q[4*i +: 4]);
    end
    enc[0] = (|bcd_q[39:32]) ? DASH : seg(bcd_q[3:0]);
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    sh_d = sh_q;
    bcd_d = bcd_q;
    bit_d = bit_q;
    ui_d = ui_q;
    hex_d = hex_q;
    case (state_q)
      IDLE: begin
        if (!halt && input_flag) begin
          state_d = WAIT_PRESS;
          stall_c = 1'b1;
        end else if (!halt && output_flag) begin
          state_d = CONVERT;
          stall_c = 1'b1;
          sh_d = out_data;
          bcd_d = '0;
          bit_d = '0;
        end
      end
      WAIT_PRESS: begin
        stall_c = !(stable && lvl_q);
        if (stable && lvl_q) begin
          ui_d = {14'b0, SW};
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        stall_c = input_flag || output_flag;
        if (stable && !lvl_q) state_d = IDLE;
      end
      CONVERT: begin
        // Final cycle publishes the digits; pending requests keep stalling until IDLE services them
        if (done) begin
          stall_c = input_flag || output_flag;
          state_d = IDLE;
          hex_d = enc;
        end else begin
          stall_c = 1'b1;
          bcd_d = {adj[38:0], sh_q[31]};
          sh_d = {sh_q[30:0], 1'b0};
          bit_d = bit_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lvl_q <= 1'b0;
      dcnt_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      bit_q <= '0;
      ui_q <= '0;
      hex_q <= '{default: BLANK};
    end else begin
      state_q <= state_d;
      lvl_q <= insert;
      dcnt_q <= dcnt_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      bit_q <= bit_d;
      ui_q <= ui_d;
      hex_q <= hex_d;
    end
  end
endmodule
